// File: rtl/alu_pkg.sv
// alu_pkg: shared widths, issue-stage states and status-flag bit positions
package alu_pkg;
   localparam int DATA_W = 16;
   localparam int REG_CNT = 8;
   localparam int REG_AW = $clog2(REG_CNT);
   typedef enum logic [1:0] {IDLE, EXEC, RETIRE} state_t;
   localparam int FLAG_C = 3;
   localparam int FLAG_Z = 2;
   localparam int FLAG_S = 1;
   localparam int FLAG_V = 0;
endpackage

// File: rtl/alu_regfile.sv
// alu_regfile: register file with two operand read ports, a debug read port and a hardwired-zero R0
module alu_regfile #(
   parameter int DATA_W = 16,
   parameter int REG_CNT = 8
) (
   input  logic                       CLK,
   input  logic                       RSTN,
   input  logic                       wrEn,
   input  logic [$clog2(REG_CNT)-1:0] wrAddr,
   input  logic [DATA_W-1:0]          wrData,
   input  logic [$clog2(REG_CNT)-1:0] rdAddrA,
   output logic [DATA_W-1:0]          rdDataA,
   input  logic [$clog2(REG_CNT)-1:0] rdAddrB,
   output logic [DATA_W-1:0]          rdDataB,
   input  logic [$clog2(REG_CNT)-1:0] dbgAddr,
   output logic [DATA_W-1:0]          dbgData
);
   import alu_pkg::*;
   logic [DATA_W-1:0] mem [REG_CNT];
   // storage; R0 is never written so it keeps its cleared value of zero
   always_ff @(posedge CLK or negedge RSTN)
      if (!RSTN)
         for (int i = 0; i < REG_CNT; i++) mem[i] <= '0;
      else if (wrEn && wrAddr != '0)
         mem[wrAddr] <= wrData;
   assign rdDataA = mem[rdAddrA];
   assign rdDataB = mem[rdAddrB];
   assign dbgData = mem[dbgAddr];
endmodule

// File: rtl/alu_issue_ctrl.sv
// alu_issue_ctrl: issues one instruction at a time to the ALU and writes its result and flags back
module alu_issue_ctrl #(
   parameter int DATA_W = 16,
   parameter int REG_CNT = 8
) (
   input  logic                       CLK,
   input  logic                       RSTN,
   input  logic                       INSTR_VALID,
   output logic                       INSTR_READY,
   input  logic                       INSTR_LOAD,
   input  logic [3:0]                 INSTR_FSEL,
   input  logic                       INSTR_USEC,
   input  logic [$clog2(REG_CNT)-1:0] INSTR_RD,
   input  logic [$clog2(REG_CNT)-1:0] INSTR_RA,
   input  logic [$clog2(REG_CNT)-1:0] INSTR_RB,
   input  logic [DATA_W-1:0]          INSTR_IMM,
   output logic [DATA_W-1:0]          ABUS,
   output logic [DATA_W-1:0]          BBUS,
   output logic [3:0]                 FSEL,
   output logic                       CIN,
   input  logic [DATA_W-1:0]          FOUT,
   input  logic                       C,
   input  logic                       Z,
   input  logic                       S,
   input  logic                       V,
   output logic [DATA_W-1:0]          RESULT,
   output logic [3:0]                 FLAGS,
   output logic                       DONE,
   input  logic [$clog2(REG_CNT)-1:0] DBG_ADDR,
   output logic [DATA_W-1:0]          DBG_DATA
);
   import alu_pkg::*;
   localparam int ADDR_W = $clog2(REG_CNT);
   state_t state, stateNext;
   logic [ADDR_W-1:0] rdLatch, wrAddr;
   logic [DATA_W-1:0] wrData, rdA, rdB;
   logic accept, wrEn;
   alu_regfile #(.DATA_W(DATA_W), .REG_CNT(REG_CNT)) regFile (
      .CLK(CLK),
      .RSTN(RSTN),
      .wrEn(wrEn),
      .wrAddr(wrAddr),
      .wrData(wrData),
      .rdAddrA(INSTR_RA),
      .rdDataA(rdA),
      .rdAddrB(INSTR_RB),
      .rdDataB(rdB),
      .dbgAddr(DBG_ADDR),
      .dbgData(DBG_DATA)
   );
   // state register; reset drops any in-flight instruction
   always_ff @(posedge CLK or negedge RSTN)
      if (!RSTN) state <= IDLE;
      else state <= stateNext;
   // loads skip EXEC since there is nothing for the ALU to compute
   always_comb
      stateNext = state == IDLE ? (INSTR_VALID ? (INSTR_LOAD ? RETIRE : EXEC) : IDLE) :
                  state == EXEC ? RETIRE : IDLE;
   // handshake, retirement pulse and register-file write selection
   always_comb begin
      INSTR_READY = state == IDLE;
      DONE = state == RETIRE;
      accept = INSTR_VALID && state == IDLE;
      wrEn = (accept && INSTR_LOAD) || state == EXEC;
      wrAddr = state == EXEC ? rdLatch : INSTR_RD;
      wrData = state == EXEC ? FOUT : INSTR_IMM;
   end
   // ALU operand latches hold until the next ALU op; RESULT/FLAGS track the last writeback
   always_ff @(posedge CLK or negedge RSTN)
      if (!RSTN) begin
         ABUS <= '0;
         BBUS <= '0;
         FSEL <= '0;
         CIN <= 1'b0;
         rdLatch <= '0;
         RESULT <= '0;
         FLAGS <= '0;
      end else begin
         if (accept && !INSTR_LOAD) begin
            ABUS <= rdA;
            BBUS <= rdB;
            FSEL <= INSTR_FSEL;
            CIN <= INSTR_USEC & FLAGS[FLAG_C];
            rdLatch <= INSTR_RD;
         end
         if (wrEn) RESULT <= wrData;
         if (state == EXEC) FLAGS <= {C, Z, S, V};
      end
endmodule

// File: tb/tb_alu_issue_ctrl.sv
// tb_alu_issue_ctrl: directed scoreboard bench for alu_issue_ctrl driving a small ALU stub
module tb_alu_issue_ctrl;
   logic CLK = 1'b0, RSTN = 1'b1;
   logic INSTR_VALID = 1'b0, INSTR_READY, INSTR_LOAD = 1'b0, INSTR_USEC = 1'b0;
   logic [3:0] INSTR_FSEL = '0, FSEL, FLAGS;
   logic [2:0] INSTR_RD = '0, INSTR_RA = '0, INSTR_RB = '0, DBG_ADDR = '0;
   logic [15:0] INSTR_IMM = '0, ABUS, BBUS, FOUT, RESULT, DBG_DATA;
   logic CIN, C, Z, S, V, DONE;
   logic [16:0] stubSum;
   typedef struct {
      logic [15:0] a;
      logic [15:0] b;
      logic cin;
      logic [15:0] res;
      logic [3:0] flg;
      logic [2:0] rd;
   } exp_t;
   exp_t sb[$];
   logic [15:0] mReg [8];
   logic [3:0] mFlags;
   int nAsserts = 0, nFail = 0;

   alu_issue_ctrl dut (
      .CLK(CLK), .RSTN(RSTN), .INSTR_VALID(INSTR_VALID), .INSTR_READY(INSTR_READY),
      .INSTR_LOAD(INSTR_LOAD), .INSTR_FSEL(INSTR_FSEL), .INSTR_USEC(INSTR_USEC),
      .INSTR_RD(INSTR_RD), .INSTR_RA(INSTR_RA), .INSTR_RB(INSTR_RB), .INSTR_IMM(INSTR_IMM),
      .ABUS(ABUS), .BBUS(BBUS), .FSEL(FSEL), .CIN(CIN), .FOUT(FOUT),
      .C(C), .Z(Z), .S(S), .V(V), .RESULT(RESULT), .FLAGS(FLAGS), .DONE(DONE),
      .DBG_ADDR(DBG_ADDR), .DBG_DATA(DBG_DATA)
   );

   always #5 CLK = ~CLK;

   // ALU stub: FSEL 0000 adds with carry-in, any other code XORs
   assign stubSum = {1'b0, ABUS} + {1'b0, BBUS} + {16'b0, CIN};
   assign FOUT = FSEL == 4'b0000 ? stubSum[15:0] : ABUS ^ BBUS;
   assign C = FSEL == 4'b0000 && stubSum[16];
   assign Z = FOUT == 16'h0000;
   assign S = FOUT[15];
   assign V = FSEL == 4'b0000 && ABUS[15] == BBUS[15] && FOUT[15] != ABUS[15];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      nAsserts++;
      assert (obs === exp) else begin
         nFail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic resetModel();
      for (int i = 0; i < 8; i++) mReg[i] = '0;
      mFlags = '0;
      sb.delete();
   endtask

   // predicts one instruction from the bench's own register model and pushes it
   task automatic predict(input logic ld, input logic [3:0] fs, input logic uc,
                          input logic [2:0] rd, input logic [2:0] ra, input logic [2:0] rb,
                          input logic [15:0] imm, output exp_t e);
      logic [16:0] sum;
      logic c, v;
      e.a = mReg[ra];
      e.b = mReg[rb];
      e.cin = uc & mFlags[3];
      e.rd = rd;
      if (ld) begin
         e.res = imm;
         e.flg = mFlags;
      end else begin
         sum = {1'b0, e.a} + {1'b0, e.b} + {16'b0, e.cin};
         if (fs == 4'b0000) begin
            e.res = sum[15:0];
            c = sum[16];
            v = (e.a[15] == e.b[15]) && (e.res[15] != e.a[15]);
         end else begin
            e.res = e.a ^ e.b;
            c = 1'b0;
            v = 1'b0;
         end
         e.flg = {c, e.res == 16'h0000, e.res[15], v};
      end
      if (rd != 3'd0) mReg[rd] = e.res;
      mFlags = e.flg;
      sb.push_back(e);
   endtask

   task automatic drive(input logic ld, input logic [3:0] fs, input logic uc,
                        input logic [2:0] rd, input logic [2:0] ra, input logic [2:0] rb,
                        input logic [15:0] imm);
      INSTR_VALID = 1'b1;
      INSTR_LOAD = ld;
      INSTR_FSEL = fs;
      INSTR_USEC = uc;
      INSTR_RD = rd;
      INSTR_RA = ra;
      INSTR_RB = rb;
      INSTR_IMM = imm;
   endtask

   // waits (bounded) for DONE, then pops the scoreboard and checks the writeback
   task automatic retire(input string tag, input int expLat, input int startLat);
      exp_t e;
      int lat = startLat;
      while (!DONE && lat < 8) begin
         @(posedge CLK); #1;
         lat++;
      end
      chk({tag, "_latency"}, 32'(lat), 32'(expLat));
      if (sb.size() == 0) chk({tag, "_sb_empty"}, 32'(sb.size()), 32'd1);
      else begin
         e = sb.pop_front();
         chk({tag, "_result"}, 32'(RESULT), 32'(e.res));
         chk({tag, "_flags"}, 32'(FLAGS), 32'(e.flg));
         DBG_ADDR = e.rd;
         #1;
         chk({tag, "_dbg"}, 32'(DBG_DATA), 32'(mReg[e.rd]));
      end
   endtask

   task automatic issue(input string tag, input logic ld, input logic [3:0] fs, input logic uc,
                        input logic [2:0] rd, input logic [2:0] ra, input logic [2:0] rb,
                        input logic [15:0] imm);
      exp_t e;
      @(negedge CLK);
      chk({tag, "_ready"}, 32'(INSTR_READY), 32'd1);
      drive(ld, fs, uc, rd, ra, rb, imm);
      predict(ld, fs, uc, rd, ra, rb, imm, e);
      @(posedge CLK); #1;
      INSTR_VALID = 1'b0;
      if (!ld) begin
         chk({tag, "_abus"}, 32'(ABUS), 32'(e.a));
         chk({tag, "_bbus"}, 32'(BBUS), 32'(e.b));
         chk({tag, "_cin"}, 32'(CIN), 32'(e.cin));
         chk({tag, "_fsel"}, 32'(FSEL), 32'(fs));
      end
      retire(tag, ld ? 1 : 2, 1);
      @(posedge CLK); #1;
      chk({tag, "_done_pulse"}, 32'(DONE), 32'd0);
      chk({tag, "_idle"}, 32'(INSTR_READY), 32'd1);
   endtask

   initial begin
      #300000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic sawDone;
      exp_t e;
      resetModel();
      #1 RSTN = 1'b0;
      repeat (2) @(negedge CLK);
      RSTN = 1'b1;
      DBG_ADDR = 3'd5;
      #1;
      chk("rst_ready", 32'(INSTR_READY), 32'd1);
      chk("rst_done", 32'(DONE), 32'd0);
      chk("rst_result", 32'(RESULT), 32'd0);
      chk("rst_flags", 32'(FLAGS), 32'd0);
      chk("rst_ops", {ABUS, BBUS}, 32'd0);
      chk("rst_fsel_cin", {27'd0, FSEL, CIN}, 32'd0);
      chk("rst_dbg", 32'(DBG_DATA), 32'd0);

      // reset in the middle of an ALU op discards it
      issue("pre_load", 1'b1, 4'b0000, 1'b0, 3'd1, 3'd0, 3'd0, 16'h1234);
      @(negedge CLK);
      drive(1'b0, 4'b0000, 1'b0, 3'd3, 3'd1, 3'd1, 16'h0000);
      @(posedge CLK); #1;
      INSTR_VALID = 1'b0;
      chk("mid_exec_busy", 32'(INSTR_READY), 32'd0);
      #2 RSTN = 1'b0;
      #1;
      chk("mid_rst_done", 32'(DONE), 32'd0);
      chk("mid_rst_flags", 32'(FLAGS), 32'd0);
      chk("mid_rst_result", 32'(RESULT), 32'd0);
      chk("mid_rst_abus", 32'(ABUS), 32'd0);
      @(negedge CLK);
      RSTN = 1'b1;
      sawDone = 1'b0;
      repeat (4) begin
         @(posedge CLK); #1;
         sawDone |= DONE;
      end
      chk("mid_rst_no_done", 32'(sawDone), 32'd0);
      chk("mid_rst_ready", 32'(INSTR_READY), 32'd1);
      DBG_ADDR = 3'd3;
      #1 chk("mid_rst_r3", 32'(DBG_DATA), 32'd0);
      DBG_ADDR = 3'd1;
      #1 chk("mid_rst_r1", 32'(DBG_DATA), 32'd0);
      resetModel();

      issue("ld_r1", 1'b1, 4'b0000, 1'b0, 3'd1, 3'd0, 3'd0, 16'h7FFF);
      issue("ld_r2", 1'b1, 4'b0000, 1'b0, 3'd2, 3'd0, 3'd0, 16'h0001);
      chk("ld_flags_zero", 32'(FLAGS), 32'd0);
      issue("add_ovf", 1'b0, 4'b0000, 1'b0, 3'd3, 3'd1, 3'd2, 16'h0000);
      chk("add_ovf_flags", 32'(FLAGS), 32'(4'b0011));
      issue("ld_r4", 1'b1, 4'b0000, 1'b0, 3'd4, 3'd0, 3'd0, 16'hFFFF);
      issue("add_carry", 1'b0, 4'b0000, 1'b0, 3'd5, 3'd4, 3'd4, 16'h0000);
      chk("add_carry_r5", 32'(RESULT), 32'h0000FFFE);
      issue("add_cin", 1'b0, 4'b0000, 1'b1, 3'd6, 3'd0, 3'd0, 16'h0000);
      chk("add_cin_r6", 32'(RESULT), 32'h00000001);
      issue("r0_write", 1'b0, 4'b0000, 1'b0, 3'd0, 3'd4, 3'd0, 16'h0000);
      chk("r0_write_result", 32'(RESULT), 32'h0000FFFF);
      issue("xor_r7", 1'b0, 4'b0101, 1'b1, 3'd7, 3'd5, 3'd4, 16'h0000);

      // back-to-back: VALID held high, second op reads the first op's destination
      @(negedge CLK);
      chk("hs_ready_a", 32'(INSTR_READY), 32'd1);
      drive(1'b0, 4'b0000, 1'b0, 3'd1, 3'd3, 3'd2, 16'h0000);
      predict(1'b0, 4'b0000, 1'b0, 3'd1, 3'd3, 3'd2, 16'h0000, e);
      @(posedge CLK); #1;
      chk("hs_busy_exec", 32'(INSTR_READY), 32'd0);
      @(negedge CLK);
      drive(1'b0, 4'b0000, 1'b1, 3'd2, 3'd1, 3'd1, 16'h0000);
      predict(1'b0, 4'b0000, 1'b1, 3'd2, 3'd1, 3'd1, 16'h0000, e);
      @(posedge CLK); #1;
      chk("hs_busy_retire", 32'(INSTR_READY), 32'd0);
      retire("hs_a", 2, 2);
      @(posedge CLK); #1;
      chk("hs_idle", 32'(INSTR_READY), 32'd1);
      @(posedge CLK); #1;
      INSTR_VALID = 1'b0;
      chk("hs_b_accept", 32'(INSTR_READY), 32'd0);
      chk("hs_b_abus", 32'(ABUS), 32'(e.a));
      chk("hs_b_cin", 32'(CIN), 32'(e.cin));
      retire("hs_b", 2, 1);
      sawDone = 1'b0;
      repeat (4) begin
         @(posedge CLK); #1;
         sawDone |= DONE;
      end
      chk("hs_no_dup", 32'(sawDone), 32'd0);
      chk("sb_drained", 32'(sb.size()), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", nAsserts, nFail);
      $finish;
   end
endmodule
